// File: rtl/bcam_upd.sv
// bcam_upd: binary CAM with valid bits, erase-then-write update engine and pipelined search.
// Optional mCnt match-count output is enabled by defining BCAM_MCNT_EN.
module bcam_upd #(
  parameter int CAMD = 256,
  parameter int CAMW = 32,
  parameter int PIPE = 0,
  parameter int INOM = 1,
  parameter int AW   = (CAMD > 1) ? $clog2(CAMD) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wReq,
  output logic            wRdy,
  input  logic [AW-1:0]   wAddr,
  input  logic [CAMW-1:0] wPatt,
  input  logic            wVld,
  output logic            wDone,
  input  logic            mReq,
  input  logic [CAMW-1:0] mPatt,
  output logic            mVal,
  output logic            match,
  output logic [AW-1:0]   mAddr,
  output logic            mMulti
`ifdef BCAM_MCNT_EN
  , output logic [$clog2(CAMD+1)-1:0] mCnt
`endif
);
  typedef enum logic [1:0] {IDLE, ERAS, WRIT} st_t;
  st_t             r_state;
  logic [AW-1:0]   r_addr;
  logic [CAMW-1:0] r_wpatt;
  logic            r_wvld;
  logic            r_done;
  logic [CAMW-1:0] r_patt [CAMD];
  logic [CAMD-1:0] r_valid;
  logic [CAMD-1:0] w_hit;
  logic            w_match;
  logic            w_multi;
  logic [AW-1:0]   w_addr;
  logic [PIPE:0]   r_v;
  logic [PIPE:0]   r_m;
  logic [PIPE:0]   r_mu;
  logic [AW-1:0]   r_a [PIPE+1];
  assign wRdy   = r_state == IDLE;
  assign wDone  = r_done;
  assign mVal   = r_v[PIPE];
  assign match  = r_m[PIPE];
  assign mMulti = r_mu[PIPE];
  assign mAddr  = r_a[PIPE];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wpatt <= '0;
      r_wvld  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done  <= r_state == WRIT;
      r_state <= r_state == IDLE ? (wReq ? ERAS : IDLE) : r_state == ERAS ? WRIT : IDLE;
      if (wReq && r_state == IDLE) begin
        r_addr  <= wAddr;
        r_wpatt <= wPatt;
        r_wvld  <= wVld;
      end
    end
  end
  // Out-of-range addresses never decode, so they run the sequence without touching the table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= INOM != 0 ? '0 : '1;
      for (int i = 0; i < CAMD; i++) r_patt[i] <= '0;
    end else begin
      for (int i = 0; i < CAMD; i++)
        if (r_addr == AW'(i)) begin
          if (r_state == ERAS) r_valid[i] <= 1'b0;
          if (r_state == WRIT) begin
            r_valid[i] <= r_wvld;
            r_patt[i]  <= r_wpatt;
          end
        end
    end
  end
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < CAMD; i++) w_hit[i] = r_valid[i] && r_patt[i] == mPatt;
  end
  // Downward scan: the last hit seen is the lowest address; multi is set if a higher hit preceded it.
  always_comb begin
    w_match = 1'b0;
    w_multi = 1'b0;
    w_addr  = '0;
    for (int i = CAMD - 1; i >= 0; i--)
      if (w_hit[i]) begin
        w_multi = w_multi | w_match;
        w_match = 1'b1;
        w_addr  = AW'(i);
      end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v  <= '0;
      r_m  <= '0;
      r_mu <= '0;
      for (int i = 0; i <= PIPE; i++) r_a[i] <= '0;
    end else begin
      r_v[0] <= mReq;
      if (mReq) begin
        r_m[0]  <= w_match;
        r_mu[0] <= w_multi;
        r_a[0]  <= w_addr;
      end
      for (int i = 1; i <= PIPE; i++) begin
        r_v[i] <= r_v[i-1];
        if (r_v[i-1]) begin
          r_m[i]  <= r_m[i-1];
          r_mu[i] <= r_mu[i-1];
          r_a[i]  <= r_a[i-1];
        end
      end
    end
  end
`ifdef BCAM_MCNT_EN
  localparam int CW = $clog2(CAMD + 1);
  logic [CW-1:0] w_cnt;
  logic [CW-1:0] r_c [PIPE+1];
  assign mCnt = r_c[PIPE];
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < CAMD; i++) w_cnt = w_cnt + CW'(w_hit[i]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= PIPE; i++) r_c[i] <= '0;
    end else begin
      if (mReq) r_c[0] <= w_cnt;
      for (int i = 1; i <= PIPE; i++)
        if (r_v[i-1]) r_c[i] <= r_c[i-1];
    end
  end
`endif
endmodule

// File: tb/tb_bcam_upd.sv
// tb_bcam_upd: scoreboard bench for bcam_upd, PIPE=0 and PIPE=2 instances sharing one stimulus stream.
module tb_bcam_upd;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic wReq = 0, wVld = 0, mReq = 0;
  logic [3:0] wAddr = 0;
  logic [7:0] wPatt = 0, mPatt = 0;
  logic wRdy0, wDone0, mVal0, match0, mMulti0, wRdy2, wDone2, mVal2, match2, mMulti2;
  logic [3:0] mAddr0, mAddr2;
`ifdef BCAM_MCNT_EN
  logic [3:0] mCnt0, mCnt2;
`endif
  bcam_upd #(.CAMD(8), .CAMW(8), .PIPE(0), .INOM(1), .AW(4)) u0 (
    .clk(clk), .rst(rst), .wReq(wReq), .wRdy(wRdy0), .wAddr(wAddr), .wPatt(wPatt), .wVld(wVld),
    .wDone(wDone0), .mReq(mReq), .mPatt(mPatt), .mVal(mVal0), .match(match0), .mAddr(mAddr0),
    .mMulti(mMulti0)
`ifdef BCAM_MCNT_EN
    , .mCnt(mCnt0)
`endif
  );
  bcam_upd #(.CAMD(8), .CAMW(8), .PIPE(2), .INOM(1), .AW(4)) u2 (
    .clk(clk), .rst(rst), .wReq(wReq), .wRdy(wRdy2), .wAddr(wAddr), .wPatt(wPatt), .wVld(wVld),
    .wDone(wDone2), .mReq(mReq), .mPatt(mPatt), .mVal(mVal2), .match(match2), .mAddr(mAddr2),
    .mMulti(mMulti2)
`ifdef BCAM_MCNT_EN
    , .mCnt(mCnt2)
`endif
  );
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int total = 0, bad = 0;
  typedef struct {logic m; logic [3:0] a; logic mu; logic [3:0] c; int due;} exp_t;
  exp_t q[2][$];
  exp_t last[2];
  logic tv[8];
  logic [7:0] tp[8];
  int free_at = 0, acc = 0, pa = 0;
  logic [7:0] pp = 0;
  logic pv = 0, pend = 0, exp_rdy = 1, exp_done = 0;
  logic [7:0] pats[5] = '{8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h3C};
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin tv[i] = 0; tp[i] = 0; end
    q[0].delete();
    q[1].delete();
    last[0] = '{default: 0};
    last[1] = '{default: 0};
    free_at = 0; pend = 0; exp_rdy = 1; exp_done = 0;
  endtask
  // Table as seen by the coming edge: searches read it before that edge's commit is applied.
  task automatic model_edge(output bit accepted);
    int e, n;
    exp_t x;
    e = cyc + 1;
    n = 0;
    accepted = 0;
    if (rst) return;
    if (mReq) begin
      x = '{default: 0};
      for (int i = 0; i < 8; i++)
        if (tv[i] && tp[i] == mPatt) begin
          if (n == 0) x.a = 4'(i);
          n++;
        end
      x.m = n > 0; x.mu = n >= 2; x.c = 4'(n);
      x.due = e; q[0].push_back(x);
      x.due = e + 2; q[1].push_back(x);
    end
    if (pend && e == acc + 1 && pa < 8) tv[pa] = 0;
    if (pend && e == acc + 2) begin
      if (pa < 8) begin tv[pa] = pv; tp[pa] = pp; end
      pend = 0;
    end
    if (wReq && e >= free_at) begin
      acc = e; pa = int'(wAddr); pp = wPatt; pv = wVld; pend = 1; free_at = e + 3; accepted = 1;
    end
  endtask
  task automatic step(output bit ok);
    model_edge(ok);
    @(posedge clk); #1;
    exp_rdy = cyc + 1 >= free_at;
    exp_done = cyc + 1 == free_at;
  endtask
  task automatic upd(int a, int p, bit v);
    bit ok = 0;
    wReq = 1; wAddr = 4'(a); wPatt = 8'(p); wVld = v;
    for (int k = 0; k < 8 && !ok; k++) step(ok);
    if (!ok) chk("accept_timeout", 0, 1);
    wReq = 0;
  endtask
  task automatic srch(int p);
    bit d;
    mReq = 1; mPatt = 8'(p);
    step(d);
    mReq = 0;
  endtask
  task automatic idle(int n);
    bit d;
    repeat (n) step(d);
  endtask
  task automatic mon(int p, logic mv, logic m, logic [3:0] a, logic mu
`ifdef BCAM_MCNT_EN
    , logic [3:0] c
`endif
  );
    exp_t e;
    if (mv) begin
      if (q[p].size() == 0) chk($sformatf("spurious_mval%0d", p), 1, 0);
      else begin
        e = q[p].pop_front();
        chk($sformatf("latency%0d", p), cyc, e.due);
        chk($sformatf("match%0d", p), m, e.m);
        chk($sformatf("maddr%0d", p), a, e.a);
        chk($sformatf("mmulti%0d", p), mu, e.mu);
`ifdef BCAM_MCNT_EN
        chk($sformatf("mcnt%0d", p), c, e.c);
`endif
        last[p] = e;
      end
    end else begin
      chk($sformatf("hold_match%0d", p), m, last[p].m);
      chk($sformatf("hold_addr%0d", p), a, last[p].a);
      chk($sformatf("hold_multi%0d", p), mu, last[p].mu);
`ifdef BCAM_MCNT_EN
      chk($sformatf("hold_cnt%0d", p), c, last[p].c);
`endif
      if (q[p].size() > 0 && q[p][0].due <= cyc) begin
        chk($sformatf("missing_mval%0d", p), 0, 1);
        void'(q[p].pop_front());
      end
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("rst_rdy", {wRdy0, wRdy2}, 2'b11);
      chk("rst_done", {wDone0, wDone2}, 0);
      chk("rst_mval", {mVal0, mVal2}, 0);
      chk("rst_match", {match0, match2, mMulti0, mMulti2}, 0);
      chk("rst_maddr", {mAddr0, mAddr2}, 0);
    end else begin
      chk("wrdy0", wRdy0, exp_rdy);
      chk("wrdy2", wRdy2, exp_rdy);
      chk("wdone0", wDone0, exp_done);
      chk("wdone2", wDone2, exp_done);
`ifdef BCAM_MCNT_EN
      mon(0, mVal0, match0, mAddr0, mMulti0, mCnt0);
      mon(1, mVal2, match2, mAddr2, mMulti2, mCnt2);
`else
      mon(0, mVal0, match0, mAddr0, mMulti0);
      mon(1, mVal2, match2, mAddr2, mMulti2);
`endif
    end
  end
  initial begin
    bit ok;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    srch(8'h00); idle(3);
    upd(3, 8'hA5, 1); idle(3); srch(8'hA5); idle(3);
    upd(6, 8'hA5, 1); idle(3); srch(8'hA5); idle(3);
    upd(3, 8'h5A, 1); srch(8'h5A); srch(8'hA5); srch(8'h5A); srch(8'hA5); idle(3);
    upd(6, 8'h00, 0); idle(3); srch(8'hA5); idle(2);
    upd(9, 8'h77, 1); idle(3); srch(8'h5A); srch(8'h77); srch(8'hA5); idle(3);
    upd(3, 8'h11, 1);
    rst = 1; model_reset(); wReq = 0; mReq = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    srch(8'h5A); srch(8'h11); idle(4);
    for (int k = 0; k < 600; k++) begin
      if (!wReq && $urandom_range(0, 2) == 0) begin
        wReq = 1;
        wAddr = 4'($urandom_range(0, 9));
        wPatt = pats[$urandom_range(0, 4)];
        wVld = $urandom_range(0, 3) != 0;
      end
      mReq = $urandom_range(0, 3) != 0;
      mPatt = pats[$urandom_range(0, 4)];
      step(ok);
      if (ok) wReq = 0;
    end
    wReq = 0; mReq = 0;
    idle(6);
    chk("drain", q[0].size() + q[1].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
